serial_subtract_ctrl: RTL
=========================

// Module: serial_subtract_ctrl
// PURPOSE
//   Bit-serial multi-bit subtractor. Sequences one full_subtracter cell
//   (a, b, bin -> difference, bout) LSB to MSB over WIDTH cycles, with a
//   registered borrow chain between bits. Computes a - b - bin on WIDTH-bit
//   unsigned operands. Use it where area matters more than latency.
//   Interface is a start/done handshake with a busy flag.
// PARAMETERS
//   WIDTH  8  operand and result width in bits; legal range 1..32
// PORTS
//   clk         in   1      single clock; all state updates on the rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   start       in   1      request; sampled only in IDLE
//   a           in   WIDTH  minuend; captured on the edge that accepts start
//   b           in   WIDTH  subtrahend; captured on the edge that accepts start
//   bin         in   1      borrow-in; captured on the edge that accepts start
//   busy        out  1      high while state != IDLE
//   done        out  1      one-cycle pulse; result valid
//   difference  out  WIDTH  result register, (a - b - bin) mod 2^WIDTH
//   bout        out  1      final borrow; 1 iff a < b + bin (unsigned)
// BEHAVIOUR
//   Reset (rst_n=0, any time, incl. mid-run)
//     - state=IDLE; counter, operand shift regs and borrow reg = 0
//     - busy=0, done=0, difference=0, bout=0
//     - any partial operation is discarded
//   FSM states: IDLE, RUN, DONE
//     IDLE: start=1 at edge E0 -> capture a, b into shift regs;
//           borrow reg <= bin; cnt <= 0; go to RUN.
//           start=0 -> stay in IDLE.
//     RUN (edges E1..E_WIDTH), once per edge:
//       - feed LSBs of the a/b shift regs plus the borrow reg into the
//         full_subtracter cell
//       - shift the cell's difference into the MSB of the result shift reg
//       - borrow reg <= cell bout; shift a/b right; cnt++
//       - at the edge where cnt == WIDTH-1: go to DONE;
//         difference <= completed result; bout <= cell bout; done <= 1
//     DONE: lasts exactly one cycle; the next edge -> IDLE, done <= 0.
//   Latency
//     - done is high in the cycle after edge E_WIDTH, i.e. WIDTH edges
//       after the edge that accepts start
//     - minimum start-to-start spacing is WIDTH+2 edges
//   Handshake
//     - start is ignored in RUN and DONE; no queuing
//     - a, b and bin may change freely after acceptance
//     - start held high continuously -> a new operation is accepted in
//       every IDLE cycle
//   Outputs
//     - difference and bout change only on the edge that raises done
//     - they hold that value until the next completion or reset
//       (not cleared at start)
//     - busy is combinational from the state register
//     - done is registered
//   Arithmetic: unsigned, modulo 2^WIDTH. WIDTH=1 reduces to the bare cell
//     plus 2 cycles of overhead.
// TESTING (WIDTH=8 unless stated; check done on the exact cycle E0+8)
//   1. a=8'h05 b=8'h03 bin=0 -> difference=8'h02 bout=0; busy high 9 cycles
//   2. a=8'h00 b=8'h01 bin=0 -> difference=8'hFF bout=1 (wrap-around)
//   3. a=8'hFF b=8'hFF bin=1 -> difference=8'hFF bout=1
//      a=8'h80 b=8'h00 bin=1 -> difference=8'h7F bout=0
//   4. start pulsed again at E3 with new operands -> ignored; result of
//      the first operation only; back-to-back start held high -> second
//      operation accepted in the cycle after done
//   5. rst_n=0 at E4 mid-run -> all outputs 0, IDLE immediately;
//      the next start completes correctly
//   6. WIDTH=1: all 8 (a,b,bin) combinations -> match full-subtracter
//      truth table (e.g. 0,1,1 -> difference=0 bout=1)

Source files
------------

// File: rtl/serial_subtract_ctrl_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
interface serial_subtract_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] difference;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, difference, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, difference, bout
    );
endinterface

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor: one full-subtracter cell stepped LSB to MSB over
// WIDTH cycles with a registered borrow between bits. Result is
// (a - b - bin) mod 2^WIDTH plus the final borrow.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one bit per edge, LSB first; leaves after bit WIDTH-1
// DONE  | single cycle with done high; result registers just updated
module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    serial_subtract_ctrl_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] diff_q;
    logic             brw;
    logic             bout_q;
    logic             done_q;
    logic             busy_c;
    logic             cell_d;
    logic             cell_bo;
    logic             last;

    // Full-subtracter cell on the current LSBs and the running borrow
    assign cell_d  = a_sr[0] ^ b_sr[0] ^ brw;
    assign cell_bo = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
    assign last    = (cnt == CW'(WIDTH - 1));

    // Result shifts in from the MSB side so bit 0 ends up at the bottom
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_nxt = cell_d;
        end else begin : g_res_wn
            assign res_nxt = {cell_d, res_sr[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; start only matters in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs from the state register
    always_comb begin
        busy_c = (state != IDLE);
    end

    // Operand shift registers, borrow chain, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr <= bus.a;
                        b_sr <= bus.b;
                        brw  <= bus.bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    res_sr <= res_nxt;
                    brw    <= cell_bo;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        diff_q <= res_nxt;
                        bout_q <= cell_bo;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_c;
    assign bus.done       = done_q;
    assign bus.difference = diff_q;
    assign bus.bout       = bout_q;

endmodule
